unpacked_window_buf: RTL and testbench

- Parametrised buffer built on an unpacked element array, with shift-in and parallel-load fill.
- Serves NCH independent read channels. Each channel selects a WIN-element slice in ascending (+:) or descending (-:) mode.
- Each slice is passed through an unpacked-array port to a pick/reduce sub-module. Per-channel results come out registered, with valid and error flags.
- Used in cosim regressions to exercise unpacked-port slicing under sequential traffic.

---
 rtl/unpacked_window_pkg.sv | 35 +++
 rtl/window_pick.sv | 22 ++
 rtl/unpacked_window_buf.sv | 115 +++++++++++
 tb/tb_unpacked_window_buf.sv | 275 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/unpacked_window_pkg.sv
// Shared constants, window mode enum and window legality rule
// for the unpacked window buffer.
package unpacked_window_pkg;

  localparam int W_D     = 4;
  localparam int DEPTH_D = 5;
  localparam int WIN_D   = 3;

  typedef enum logic {
    WIN_ASC  = 1'b0,
    WIN_DESC = 1'b1
  } win_mode_e;

  // Legal when the whole window lies inside the array
  // and its highest index has already been filled.
  function automatic logic win_legal(
    int        base,
    win_mode_e mode,
    int        cnt,
    int        depth = DEPTH_D,
    int        win   = WIN_D
  );
    int hi;
    if (base < 0 || base >= depth) return 1'b0;
    if (mode == WIN_DESC) begin
      if (base < win - 1) return 1'b0;
      hi = base;
    end else begin
      hi = base + win - 1;
      if (hi > depth - 1) return 1'b0;
    end
    return (hi < cnt);
  endfunction

endpackage

// File: rtl/window_pick.sv
// Combinational reduce of one window: last element and
// XOR of all elements.
module window_pick
  import unpacked_window_pkg::*;
#(
  parameter int W   = W_D,
  parameter int WIN = WIN_D
) (
  input  logic [W-1:0] f [WIN],
  output logic [W-1:0] pick,
  output logic [W-1:0] x
);

  assign pick = f[WIN-1];

  always_comb begin
    x = '0;
    for (int k = 0; k < WIN; k++)
      x = x ^ f[k];
  end

endmodule

// File: rtl/unpacked_window_buf.sv
// Shift/load element buffer with NCH windowed read channels
// and registered per-channel pick/XOR results.
module unpacked_window_buf
  import unpacked_window_pkg::*;
#(
  parameter int  W     = W_D,
  parameter int  DEPTH = DEPTH_D,
  parameter int  WIN   = WIN_D,
  parameter int  NCH   = 2,
  localparam int IDXW  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNTW  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [W*DEPTH-1:0] load_data,
  input  logic              push,
  input  logic [W-1:0]      push_data,
  input  logic [NCH-1:0]    chan_req,
  input  logic [NCH-1:0]    chan_desc,
  input  logic [NCH*IDXW-1:0] chan_base,
  output logic [NCH-1:0]    out_valid,
  output logic [NCH-1:0]    out_err,
  output logic [NCH*W-1:0]  out_pick,
  output logic [NCH*W-1:0]  out_xor,
  output logic [CNTW-1:0]   count
);

  logic [W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= '0;
      count <= '0;
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= load_data[i*W +: W];
      count <= CNTW'(DEPTH);
    end else if (push) begin
      mem[0] <= push_data;
      for (int i = 1; i < DEPTH; i++)
        mem[i] <= mem[i-1];
      if (count != CNTW'(DEPTH))
        count <= count + 1'b1;
    end
  end

  for (genvar c = 0; c < NCH; c++) begin : g_ch
    logic [IDXW-1:0] base;
    win_mode_e       mode;
    logic            legal;
    int              lo;
    logic [W-1:0]    f [WIN];
    logic [W-1:0]    pick;
    logic [W-1:0]    x;
    logic            v_q;
    logic            e_q;
    logic [W-1:0]    p_q;
    logic [W-1:0]    x_q;

    assign base  = chan_base[c*IDXW +: IDXW];
    assign mode  = win_mode_e'(chan_desc[c]);
    assign legal = win_legal(int'(base), mode,
                             int'(count), DEPTH, WIN);

    // Low index picked from constant candidates so an
    // out-of-range base never addresses mem.
    always_comb begin
      lo = (mode == WIN_DESC) ? int'(base) - (WIN - 1)
                              : int'(base);
      for (int k = 0; k < WIN; k++)
        f[k] = '0;
      if (legal) begin
        for (int l = 0; l <= DEPTH - WIN; l++) begin
          if (lo == l) begin
            for (int k = 0; k < WIN; k++)
              f[k] = mem[l+k];
          end
        end
      end
    end

    window_pick #(
      .W   (W),
      .WIN (WIN)
    ) u_pick (
      .f    (f),
      .pick (pick),
      .x    (x)
    );

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        e_q <= 1'b0;
        p_q <= '0;
        x_q <= '0;
      end else if (chan_req[c]) begin
        v_q <= 1'b1;
        e_q <= !legal;
        p_q <= legal ? pick : '0;
        x_q <= legal ? x : '0;
      end else begin
        v_q <= 1'b0;
      end
    end

    assign out_valid[c]         = v_q;
    assign out_err[c]           = e_q;
    assign out_pick[c*W +: W]   = p_q;
    assign out_xor[c*W +: W]    = x_q;
  end

endmodule

// File: tb/tb_unpacked_window_buf.sv
// Directed plus short random bench for unpacked_window_buf
// with a reference model and result scoreboard.
module tb_unpacked_window_buf;

  localparam int W     = 4;
  localparam int DEPTH = 5;
  localparam int WIN   = 3;
  localparam int NCH   = 2;
  localparam int IDXW  = 3;
  localparam int CNTW  = 3;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              load;
  logic [W*DEPTH-1:0] load_data;
  logic              push;
  logic [W-1:0]      push_data;
  logic [NCH-1:0]    chan_req;
  logic [NCH-1:0]    chan_desc;
  logic [NCH*IDXW-1:0] chan_base;
  logic [NCH-1:0]    out_valid;
  logic [NCH-1:0]    out_err;
  logic [NCH*W-1:0]  out_pick;
  logic [NCH*W-1:0]  out_xor;
  logic [CNTW-1:0]   count;

  unpacked_window_buf dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .push      (push),
    .push_data (push_data),
    .chan_req  (chan_req),
    .chan_desc (chan_desc),
    .chan_base (chan_base),
    .out_valid (out_valid),
    .out_err   (out_err),
    .out_pick  (out_pick),
    .out_xor   (out_xor),
    .count     (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         ch;
    logic       err;
    logic [W-1:0] pick;
    logic [W-1:0] xr;
  } exp_t;

  exp_t         q[$];
  logic [W-1:0] mm [DEPTH];
  int           cnt;
  logic [W-1:0] last_pick [NCH];
  logic [W-1:0] last_xor  [NCH];
  logic         last_err  [NCH];
  int           n_assert = 0;
  int           n_fail   = 0;

  task automatic chk(string tag, logic [31:0] o, logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  function automatic exp_t model(int c);
    exp_t r;
    int   b;
    int   lo;
    int   hi;
    logic ok;
    b  = int'(chan_base[c*IDXW +: IDXW]);
    if (chan_desc[c]) begin
      hi = b;
      lo = b - (WIN - 1);
    end else begin
      lo = b;
      hi = b + WIN - 1;
    end
    ok = (lo >= 0) && (hi <= DEPTH - 1) && (hi < cnt);
    r.ch   = c;
    r.err  = !ok;
    r.pick = '0;
    r.xr   = '0;
    if (ok) begin
      r.pick = mm[hi];
      for (int k = lo; k <= hi; k++)
        r.xr = r.xr ^ mm[k];
    end
    return r;
  endfunction

  task automatic req(int c, logic d, int b);
    chan_req[c]  = 1'b1;
    chan_desc[c] = d;
    chan_base[c*IDXW +: IDXW] = IDXW'(b);
  endtask

  task automatic cycle();
    exp_t           e;
    logic [NCH-1:0] ev;
    ev = '0;
    if (rst_n) begin
      for (int c = 0; c < NCH; c++) begin
        if (chan_req[c]) begin
          q.push_back(model(c));
          ev[c] = 1'b1;
        end
      end
    end
    @(posedge clk);
    #1;
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) mm[i] = '0;
      cnt = 0;
      q.delete();
      for (int c = 0; c < NCH; c++) begin
        last_pick[c] = '0;
        last_xor[c]  = '0;
        last_err[c]  = 1'b0;
      end
    end else if (load) begin
      for (int i = 0; i < DEPTH; i++)
        mm[i] = load_data[i*W +: W];
      cnt = DEPTH;
    end else if (push) begin
      for (int i = DEPTH - 1; i > 0; i--)
        mm[i] = mm[i-1];
      mm[0] = push_data;
      if (cnt < DEPTH) cnt++;
    end
    @(negedge clk);
    chk("valid", 32'(out_valid), 32'(ev));
    while (q.size() > 0) begin
      e = q.pop_front();
      last_pick[e.ch] = e.pick;
      last_xor[e.ch]  = e.xr;
      last_err[e.ch]  = e.err;
    end
    for (int c = 0; c < NCH; c++) begin
      chk($sformatf("pick%0d", c),
          32'(out_pick[c*W +: W]), 32'(last_pick[c]));
      chk($sformatf("xor%0d", c),
          32'(out_xor[c*W +: W]), 32'(last_xor[c]));
      chk($sformatf("err%0d", c),
          32'(out_err[c]), 32'(last_err[c]));
    end
    chk("count", 32'(count), 32'(cnt));
    chan_req = '0;
    load     = 1'b0;
    push     = 1'b0;
  endtask

  task automatic do_push(logic [W-1:0] d);
    push      = 1'b1;
    push_data = d;
    cycle();
  endtask

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    load_data = '0;
    push      = 1'b0;
    push_data = '0;
    chan_req  = '0;
    chan_desc = '0;
    chan_base = '0;
    cnt       = 0;
    for (int i = 0; i < DEPTH; i++) mm[i] = 'x;
    @(negedge clk);
    cycle();
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_pick", 32'(out_pick), 32'd0);
    chk("rst_xor", 32'(out_xor), 32'd0);
    chk("rst_count", 32'(count), 32'd0);

    rst_n     = 1'b1;
    load      = 1'b1;
    load_data = 20'h43210;
    cycle();
    chk("load_count", 32'(count), 32'd5);

    req(0, 1'b0, 0);
    cycle();
    chk("asc0_valid", 32'(out_valid[0]), 32'd1);
    chk("asc0_pick", 32'(out_pick[3:0]), 32'h2);
    chk("asc0_xor", 32'(out_xor[3:0]), 32'h3);

    req(1, 1'b1, 3);
    req(0, 1'b0, 2);
    cycle();
    chk("dual_valid", 32'(out_valid), 32'h3);
    chk("desc3_pick", 32'(out_pick[7:4]), 32'h3);
    chk("desc3_xor", 32'(out_xor[7:4]), 32'h0);
    chk("asc2_pick", 32'(out_pick[3:0]), 32'h4);
    chk("asc2_xor", 32'(out_xor[3:0]), 32'h5);

    req(0, 1'b0, 3);
    req(1, 1'b1, 1);
    cycle();
    chk("bad_err", 32'(out_err), 32'h3);
    chk("bad_pick", 32'(out_pick), 32'h0);
    chk("bad_xor", 32'(out_xor), 32'h0);

    cycle();
    chk("hold_err", 32'(out_err), 32'h3);

    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    do_push(4'hA);
    do_push(4'hB);
    chk("push2_count", 32'(count), 32'd2);
    req(0, 1'b0, 0);
    cycle();
    chk("unfilled_err", 32'(out_err[0]), 32'd1);
    do_push(4'hC);
    req(0, 1'b0, 0);
    cycle();
    chk("fill_err", 32'(out_err[0]), 32'd0);
    chk("fill_pick", 32'(out_pick[3:0]), 32'hA);
    chk("fill_xor", 32'(out_xor[3:0]), 32'hD);

    rst_n = 1'b0;
    cycle();
    rst_n = 1'b1;
    for (int i = 1; i <= 7; i++) do_push(4'(i));
    chk("sat_count", 32'(count), 32'd5);
    req(1, 1'b1, 4);
    cycle();
    chk("sat_pick", 32'(out_pick[7:4]), 32'h3);
    chk("sat_xor", 32'(out_xor[7:4]), 32'h2);

    load      = 1'b1;
    load_data = 20'hFFFFF;
    req(0, 1'b0, 0);
    cycle();
    chk("old_pick", 32'(out_pick[3:0]), 32'h5);
    chk("old_xor", 32'(out_xor[3:0]), 32'h4);
    req(0, 1'b0, 0);
    cycle();
    chk("new_pick", 32'(out_pick[3:0]), 32'hF);
    chk("new_xor", 32'(out_xor[3:0]), 32'hF);

    req(0, 1'b0, 1);
    req(1, 1'b1, 2);
    rst_n = 1'b0;
    cycle();
    chk("rstreq_valid", 32'(out_valid), 32'd0);
    chk("rstreq_count", 32'(count), 32'd0);
    rst_n = 1'b1;

    for (int n = 0; n < 40; n++) begin
      load      = ($urandom_range(0, 7) == 0);
      load_data = 20'($urandom);
      push      = ($urandom_range(0, 1) == 1);
      push_data = 4'($urandom);
      for (int c = 0; c < NCH; c++) begin
        if ($urandom_range(0, 2) != 0)
          req(c, 1'($urandom), int'($urandom_range(0, 7)));
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
